zic_active_level_stack: RTL and testbench
=========================================

ZIC_ACTIVE_LEVEL_STACK -- requirements
Module: zic_active_level_stack

Purpose: tracks nested in-service interrupts between ZIC ack/EOI and the CSR; produces the active level-priority value consumed by the ZIC as active_lvl_pr_i.

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the maximum nesting depth (number of stack entries), legal range 2..15.
REQ-002 SHALL have port zic_clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port zic_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ack_valid_i, input, 1 bit: one-cycle pulse marking an interrupt acknowledge.
REQ-005 SHALL have port ack_id_i, input, 8 bits: the ID of the acknowledged interrupt.
REQ-006 SHALL have port ack_lvl_pr_i, input, 8 bits: the level-priority value of the acknowledged interrupt.
REQ-007 SHALL have port eoi_valid_i, input, 1 bit: one-cycle pulse marking an end of interrupt.
REQ-008 SHALL have port eoi_id_i, input, 8 bits: the ID being retired.
REQ-009 SHALL have port debug_mode_valid_i, input, 1 bit: the core is in debug mode.
REQ-010 SHALL have port err_clr_i, input, 1 bit: clears all sticky error flags.
REQ-011 SHALL have port active_lvl_pr_o, output, 8 bits: the current active level-priority value.
REQ-012 SHALL have port active_id_o, output, 8 bits: the ID at the top of the stack.
REQ-013 SHALL have port active_valid_o, output, 1 bit: the stack is non-empty.
REQ-014 SHALL have port depth_o, output, 4 bits: the current number of entries.
REQ-015 SHALL have port overflow_err_o, output, 1 bit: sticky flag set on a push attempted while the stack is full.
REQ-016 SHALL have port underflow_err_o, output, 1 bit: sticky flag set on an EOI received while the stack is empty.
REQ-017 SHALL have port mismatch_err_o, output, 1 bit: sticky flag set when an EOI ID does not match the top-of-stack ID.
REQ-018 SHALL have port preempt_err_o, output, 1 bit: sticky flag set when an ack has a level-priority not greater than the current active value.

Function
REQ-019 SHALL store DEPTH entries of {id[7:0], lvl_pr[7:0]} in a LIFO, indexed by a depth counter running 0..DEPTH.
REQ-020 SHALL drive all outputs from registers, so an ack or EOI takes effect on the outputs one cycle after the input edge.
REQ-021 SHALL, with depth 0, drive active_lvl_pr_o = 8'h00, active_id_o = 8'h00 and active_valid_o = 0.
REQ-022 SHALL, with depth non-zero, drive active_lvl_pr_o and active_id_o from the top entry.
REQ-023 SHALL accept an ack as a push only when ack_lvl_pr_i > the effective active value, compared unsigned over 8 bits, and depth < DEPTH.
REQ-024 SHALL treat a push as follows: write the entry at index depth, then increment depth.
REQ-025 SHALL, when ack_lvl_pr_i <= the effective active value, drop the ack, leave the stack unchanged and set preempt_err_o.
REQ-026 SHALL, when an ack arrives with depth == DEPTH, drop the ack, leave the stack unchanged and set overflow_err_o.
REQ-027 SHALL, when an EOI arrives with depth > 0 and eoi_id_i equal to the top ID, pop the stack by decrementing depth.
REQ-028 SHALL, when an EOI arrives with depth > 0 and eoi_id_i different from the top ID, not pop and set mismatch_err_o.
REQ-029 SHALL, when an EOI arrives with depth == 0, leave the stack unchanged and set underflow_err_o.
REQ-030 SHALL, when ack and EOI arrive in the same cycle, evaluate the EOI first and then evaluate the ack against the post-EOI top and depth, with both taking effect in that one cycle.
REQ-031 SHALL, in the simultaneous case with a full stack and a matching EOI, accept the push with no overflow and leave depth unchanged.
REQ-032 SHALL, while debug_mode_valid_i = 1, force active_lvl_pr_o to 8'hFF, ignore ack and EOI without setting any flag, and freeze the stack.
REQ-033 SHALL restore the top entry value on active_lvl_pr_o the cycle after debug_mode_valid_i falls.
REQ-034 SHALL, when err_clr_i is asserted, clear all four sticky flags on the next edge.
REQ-035 SHALL, when err_clr_i and a new error occur in the same cycle, set the flag for that new error, so set wins over clear.
REQ-036 SHALL keep depth_o equal to the depth counter, and never let it exceed DEPTH or go below 0.

Reset
REQ-037 SHALL, on zic_rst = 1 at a clock edge, set depth to 0 and clear all error flags.
REQ-038 SHALL, on reset, set active_lvl_pr_o = 8'h00, active_id_o = 8'h00 and active_valid_o = 0.
REQ-039 SHALL let reset override every other input, including reset asserted in the middle of nesting.
REQ-040 SHALL, on reset, not require the entry storage contents to be cleared.

Verification
REQ-041 Nested push/pop: ack(id 5, 8'h20), then ack(id 9, 8'h40) -> active 8'h40, depth 2; EOI 9 -> 8'h20, depth 1; EOI 5 -> 8'h00, active_valid 0.
REQ-042 Preemption reject: with active 8'h40, ack(id 3, 8'h40) -> dropped, depth unchanged, preempt_err_o = 1; then err_clr_i -> flag 0.
REQ-043 Full/empty: DEPTH = 8, pushes at 8'h10..8'h80 -> depth 8; 9th ack at 8'h90 -> overflow_err_o = 1, depth 8; eight matching EOIs, then one extra EOI -> underflow_err_o = 1.
REQ-044 Simultaneous events: depth 1 (id 5, 8'h20); same cycle EOI 5 and ack(id 7, 8'h10) -> depth 1, top id 7, active 8'h10, no flags set.
REQ-045 Mismatch: top id 9, EOI 5 -> mismatch_err_o = 1, depth unchanged.
REQ-046 Debug and reset: debug_mode_valid_i = 1 -> active 8'hFF and ack ignored; deassert -> prior value back next cycle; zic_rst at depth 3 -> depth 0, all outputs 0 next cycle.

Source files
------------

// File: rtl/zic_active_level_stack.sv
// Nested in-service interrupt tracker sitting between ZIC ack/EOI and the CSR.
// Supplies the active level-priority that the ZIC uses as its preemption threshold.
module zic_active_level_stack #(
  parameter int DEPTH = 8
) (
  input  logic       zic_clk,
  input  logic       zic_rst,
  input  logic       ack_valid_i,
  input  logic [7:0] ack_id_i,
  input  logic [7:0] ack_lvl_pr_i,
  input  logic       eoi_valid_i,
  input  logic [7:0] eoi_id_i,
  input  logic       debug_mode_valid_i,
  input  logic       err_clr_i,
  output logic [7:0] active_lvl_pr_o,
  output logic [7:0] active_id_o,
  output logic       active_valid_o,
  output logic [3:0] depth_o,
  output logic       overflow_err_o,
  output logic       underflow_err_o,
  output logic       mismatch_err_o,
  output logic       preempt_err_o
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  // Entry storage: {id, lvl_pr}; deliberately not reset.
  logic [15:0]   stack_q [DEPTH];

  logic [3:0]    depth_q, depth_mid, depth_d;
  logic [7:0]    active_lvl_q, active_lvl_d;
  logic [7:0]    active_id_q, active_id_d;
  logic          active_valid_q, active_valid_d;
  logic          overflow_q, underflow_q, mismatch_q, preempt_q;
  logic          overflow_set, underflow_set, mismatch_set, preempt_set;
  logic          push;

  logic [IW-1:0] cur_idx, mid_idx, nxt_idx, wr_idx;
  logic [7:0]    cur_id;
  logic [7:0]    mid_lvl_raw, mid_lvl;
  logic [15:0]   nxt_top;

  assign cur_idx = IW'(depth_q - 4'd1);
  assign cur_id  = stack_q[cur_idx][15:8];

  // EOI is resolved first; the ack is then judged against the post-EOI top.
  always_comb begin
    depth_mid     = depth_q;
    underflow_set = 1'b0;
    mismatch_set  = 1'b0;
    if (!debug_mode_valid_i && eoi_valid_i) begin
      if (depth_q == 4'd0) begin
        underflow_set = 1'b1;
      end else if (eoi_id_i == cur_id) begin
        depth_mid = depth_q - 4'd1;
      end else begin
        mismatch_set = 1'b1;
      end
    end
  end

  assign mid_idx     = IW'(depth_mid - 4'd1);
  assign mid_lvl_raw = stack_q[mid_idx][7:0];
  assign mid_lvl     = (depth_mid == 4'd0) ? 8'h00 : mid_lvl_raw;
  assign wr_idx      = IW'(depth_mid);

  always_comb begin
    overflow_set = 1'b0;
    preempt_set  = 1'b0;
    push         = 1'b0;
    if (!debug_mode_valid_i && ack_valid_i) begin
      if (depth_mid == DEPTH_L) begin
        overflow_set = 1'b1;
      end
      if (ack_lvl_pr_i <= mid_lvl) begin
        preempt_set = 1'b1;
      end
      push = !overflow_set && !preempt_set;
    end
    depth_d = push ? (depth_mid + 4'd1) : depth_mid;
  end

  assign nxt_idx = IW'(depth_d - 4'd1);
  assign nxt_top = stack_q[nxt_idx];

  // Registered view of the post-update top entry.
  always_comb begin
    active_valid_d = (depth_d != 4'd0);
    active_lvl_d   = 8'h00;
    active_id_d    = 8'h00;
    if (push) begin
      active_lvl_d = ack_lvl_pr_i;
      active_id_d  = ack_id_i;
    end else if (depth_d != 4'd0) begin
      active_lvl_d = nxt_top[7:0];
      active_id_d  = nxt_top[15:8];
    end
    if (debug_mode_valid_i) begin
      active_lvl_d = 8'hFF;
    end
  end

  always_ff @(posedge zic_clk) begin
    if (push && !zic_rst) begin
      stack_q[wr_idx] <= {ack_id_i, ack_lvl_pr_i};
    end
  end

  always_ff @(posedge zic_clk) begin
    if (zic_rst) begin
      depth_q        <= 4'd0;
      active_lvl_q   <= 8'h00;
      active_id_q    <= 8'h00;
      active_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      preempt_q      <= 1'b0;
    end else begin
      depth_q        <= depth_d;
      active_lvl_q   <= active_lvl_d;
      active_id_q    <= active_id_d;
      active_valid_q <= active_valid_d;
      // A new error in the clearing cycle still sets its flag.
      overflow_q     <= (overflow_q  & ~err_clr_i) | overflow_set;
      underflow_q    <= (underflow_q & ~err_clr_i) | underflow_set;
      mismatch_q     <= (mismatch_q  & ~err_clr_i) | mismatch_set;
      preempt_q      <= (preempt_q   & ~err_clr_i) | preempt_set;
    end
  end

  assign active_lvl_pr_o = active_lvl_q;
  assign active_id_o     = active_id_q;
  assign active_valid_o  = active_valid_q;
  assign depth_o         = depth_q;
  assign overflow_err_o  = overflow_q;
  assign underflow_err_o = underflow_q;
  assign mismatch_err_o  = mismatch_q;
  assign preempt_err_o   = preempt_q;

endmodule

// File: tb/tb_zic_active_level_stack.sv
// Directed bench for zic_active_level_stack: a vector table of single-cycle steps
// plus hand-written full/empty and simultaneous-event sequences.
module tb_zic_active_level_stack;

  logic       clk = 1'b0;
  logic       rst, ack_v, eoi_v, dbg, clr;
  logic [7:0] ack_id, ack_lvl, eoi_id;
  logic [7:0] lvl_o, id_o;
  logic       valid_o, ov_o, un_o, mm_o, pe_o;
  logic [3:0] depth_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zic_active_level_stack #(.DEPTH(8)) dut (
    .zic_clk(clk), .zic_rst(rst),
    .ack_valid_i(ack_v), .ack_id_i(ack_id), .ack_lvl_pr_i(ack_lvl),
    .eoi_valid_i(eoi_v), .eoi_id_i(eoi_id),
    .debug_mode_valid_i(dbg), .err_clr_i(clr),
    .active_lvl_pr_o(lvl_o), .active_id_o(id_o), .active_valid_o(valid_o),
    .depth_o(depth_o), .overflow_err_o(ov_o), .underflow_err_o(un_o),
    .mismatch_err_o(mm_o), .preempt_err_o(pe_o)
  );

  typedef struct {
    string      name;
    logic       rst, ack_v;
    logic [7:0] ack_id, ack_lvl;
    logic       eoi_v;
    logic [7:0] eoi_id;
    logic       dbg, clr;
    logic [7:0] e_lvl, e_id;
    logic       e_valid;
    logic [3:0] e_depth;
    logic [3:0] e_flags; // {ov, un, mm, pe}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic av, input logic [7:0] ai,
                     input logic [7:0] al, input logic ev, input logic [7:0] ei,
                     input logic d, input logic c, input logic [7:0] el, input logic [7:0] eid,
                     input logic evl, input logic [3:0] edp, input logic [3:0] efl);
    vec_t v;
    v.name = nm; v.rst = r; v.ack_v = av; v.ack_id = ai; v.ack_lvl = al;
    v.eoi_v = ev; v.eoi_id = ei; v.dbg = d; v.clr = c;
    v.e_lvl = el; v.e_id = eid; v.e_valid = evl; v.e_depth = edp; v.e_flags = efl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic av, input logic [7:0] ai, input logic [7:0] al,
                       input logic ev, input logic [7:0] ei, input logic d, input logic c);
    rst = r; ack_v = av; ack_id = ai; ack_lvl = al;
    eoi_v = ev; eoi_id = ei; dbg = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] el, input logic [7:0] eid,
                       input logic evl, input logic [3:0] edp, input logic [3:0] efl);
    logic [24:0] act, exp;
    act = {lvl_o, id_o, valid_o, depth_o, ov_o, un_o, mm_o, pe_o};
    exp = {el, eid, evl, edp, efl};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl=%h id=%h valid=%b depth=%0d flags(ov,un,mm,pe)=%b, expected lvl=%h id=%h valid=%b depth=%0d flags=%b",
               nm, lvl_o, id_o, valid_o, depth_o, {ov_o, un_o, mm_o, pe_o}, el, eid, evl, edp, efl);
    end
  endtask

  initial begin
    //   name            rst av id     lvl    ev id     dbg clr  e_lvl  e_id  v  dep  flags
    add("reset",          1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("idle",           0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("push5",          0, 1, 8'h05, 8'h20, 0, 8'h00, 0, 0, 8'h20, 8'h05, 1, 1, 4'b0000);
    add("push9",          0, 1, 8'h09, 8'h40, 0, 8'h00, 0, 0, 8'h40, 8'h09, 1, 2, 4'b0000);
    add("preempt_eq",     0, 1, 8'h03, 8'h40, 0, 8'h00, 0, 0, 8'h40, 8'h09, 1, 2, 4'b0001);
    add("clr_pe",         0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h40, 8'h09, 1, 2, 4'b0000);
    add("mismatch",       0, 0, 8'h00, 8'h00, 1, 8'h05, 0, 0, 8'h40, 8'h09, 1, 2, 4'b0010);
    add("set_beats_clr",  0, 0, 8'h00, 8'h00, 1, 8'h05, 0, 1, 8'h40, 8'h09, 1, 2, 4'b0010);
    add("clr_mm",         0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h40, 8'h09, 1, 2, 4'b0000);
    add("eoi9",           0, 0, 8'h00, 8'h00, 1, 8'h09, 0, 0, 8'h20, 8'h05, 1, 1, 4'b0000);
    add("eoi5_ack7",      0, 1, 8'h07, 8'h10, 1, 8'h05, 0, 0, 8'h10, 8'h07, 1, 1, 4'b0000);
    add("eoi7",           0, 0, 8'h00, 8'h00, 1, 8'h07, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("underflow",      0, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0100);
    add("clr_un",         0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("ack_lvl0_empty", 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0001);
    add("clr_pe2",        0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("push5_again",    0, 1, 8'h05, 8'h20, 0, 8'h00, 0, 0, 8'h20, 8'h05, 1, 1, 4'b0000);
    add("dbg_on",         0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'hFF, 8'h05, 1, 1, 4'b0000);
    add("dbg_ack",        0, 1, 8'h06, 8'h30, 0, 8'h00, 1, 0, 8'hFF, 8'h05, 1, 1, 4'b0000);
    add("dbg_eoi_bad",    0, 0, 8'h00, 8'h00, 1, 8'h09, 1, 0, 8'hFF, 8'h05, 1, 1, 4'b0000);
    add("dbg_off",        0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h20, 8'h05, 1, 1, 4'b0000);
    add("push6",          0, 1, 8'h06, 8'h30, 0, 8'h00, 0, 0, 8'h30, 8'h06, 1, 2, 4'b0000);
    add("push7",          0, 1, 8'h07, 8'h50, 0, 8'h00, 0, 0, 8'h50, 8'h07, 1, 3, 4'b0000);
    add("rst_mid_nest",   1, 1, 8'h08, 8'h60, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add("after_rst",      0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack_v, vecs[i].ack_id, vecs[i].ack_lvl,
            vecs[i].eoi_v, vecs[i].eoi_id, vecs[i].dbg, vecs[i].clr);
      check(vecs[i].name, vecs[i].e_lvl, vecs[i].e_id, vecs[i].e_valid,
            vecs[i].e_depth, vecs[i].e_flags);
    end

    // Fill to DEPTH with ids 1..8 at 8'h10..8'h80.
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 8'(k), 8'(k * 16), 0, 0, 0, 0);
      check($sformatf("fill%0d", k), 8'(k * 16), 8'(k), 1, 4'(k), 4'b0000);
    end
    drive(0, 1, 8'h09, 8'h90, 0, 0, 0, 0);
    check("overflow", 8'h80, 8'h08, 1, 4'd8, 4'b1000);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("clr_ov", 8'h80, 8'h08, 1, 4'd8, 4'b0000);

    // Full stack, matching EOI plus ack in one cycle: replace top, no overflow.
    drive(0, 1, 8'h14, 8'h75, 1, 8'h08, 0, 0);
    check("full_swap", 8'h75, 8'h14, 1, 4'd8, 4'b0000);

    drive(0, 0, 0, 0, 1, 8'h14, 0, 0);
    check("drain8", 8'h70, 8'h07, 1, 4'd7, 4'b0000);
    for (int k = 7; k >= 2; k--) begin
      drive(0, 0, 0, 0, 1, 8'(k), 0, 0);
      check($sformatf("drain%0d", k), 8'((k - 1) * 16), 8'(k - 1), 1, 4'(k - 1), 4'b0000);
    end
    drive(0, 0, 0, 0, 1, 8'h01, 0, 0);
    check("drain1", 8'h00, 8'h00, 0, 4'd0, 4'b0000);
    drive(0, 0, 0, 0, 1, 8'h01, 0, 0);
    check("extra_eoi", 8'h00, 8'h00, 0, 4'd0, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
